// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode encodings, IR reset value
// and the fetch FSM state type.
package cpu_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_PASS  = 2'b11;

  // PASS opcode with a zero operand: harmless if executed before the first fetch.
  localparam logic [7:0] IR_RESET_DEFAULT = 8'hC0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  function automatic logic [1:0] ir_opcode(input logic [7:0] i_ir);
    return i_ir[7:6];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load has priority over increment, increment wraps
// modulo 2^AW. Shared with the datapath.
module fetch_pc_reg #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ld,
  input  logic          i_inc,
  input  logic [AW-1:0] i_d,
  output logic [AW-1:0] o_q
);

  logic [AW-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end else if (i_inc) begin
      r_q <= r_q + AW'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding read, latches IR.
// Define FETCH_TIMEOUT_EN to enable the WAIT-state timeout and sticky fetch_err.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int         AW       = 8,
  parameter logic [7:0] IR_RESET = IR_RESET_DEFAULT,
  parameter int         TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_ir,
  input  logic          ld_pc,
  input  logic          inc_pc,
  input  logic [AW-1:0] jmp_addr,
  output logic          mem_rd_req,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_rvalid,
  output logic [7:0]    ir,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic          fetch_busy,
  output logic          fetch_err,
  output fetch_state_t  dbg_state
);

  // Handshake: mem_rd_req is a one-cycle strobe with mem_addr stable alongside it;
  // the memory answers with one mem_rvalid strobe per request, in order, no backpressure.

  fetch_state_t  r_state;
  logic          r_mem_rd_req;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_ir;
  logic          r_ir_valid;
  logic          r_busy;
  logic [AW-1:0] w_pc;

  fetch_pc_reg #(.AW(AW)) u_pc (
    .i_clk   (clk),
    .i_reset (reset),
    .i_ld    (ld_pc),
    .i_inc   (inc_pc),
    .i_d     (jmp_addr),
    .o_q     (w_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mem_rd_req <= 1'b0;
      r_mem_addr   <= '0;
      r_ir         <= IR_RESET;
      r_ir_valid   <= 1'b0;
      r_busy       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_cnt        <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_mem_rd_req <= 1'b0;
      r_ir_valid   <= 1'b0;
      case (r_state)
        IDLE: begin
          // w_pc is the pre-update value, so a coincident ld_pc/inc_pc is not seen here.
          if (ld_ir) begin
            r_state    <= REQ;
            r_mem_addr <= w_pc;
            r_busy     <= 1'b1;
          end
        end
        REQ: begin
          r_mem_rd_req <= 1'b1;
          r_state      <= WAIT;
`ifdef FETCH_TIMEOUT_EN
          r_cnt        <= '0;
`endif
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_ir       <= mem_rdata;
            r_ir_valid <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state <= ERR;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end
        ERR: begin
          r_state <= ERR;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_rd_req = r_mem_rd_req;
  assign mem_addr   = r_mem_addr;
  assign ir         = r_ir;
  assign ir_valid   = r_ir_valid;
  assign pc         = w_pc;
  assign fetch_busy = r_busy;
  assign dbg_state  = r_state;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err  = r_err;
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC vector table, fetch scoreboard and
// hand-written WAIT / reset / timeout sequences.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_ir;
  logic          ld_pc;
  logic          inc_pc;
  logic [AW-1:0] jmp_addr;
  logic          mem_rd_req;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_rvalid;
  logic [7:0]    ir;
  logic          ir_valid;
  logic [AW-1:0] pc;
  logic          fetch_busy;
  logic          fetch_err;
  fetch_state_t  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tb_mem [256];

  typedef struct {
    logic       ld_pc;
    logic       inc;
    logic [7:0] jmp;
    logic       fetch;
    int         lat;
    logic [7:0] exp_pc;
  } vec_t;
  vec_t vecs [10];

  fetch_unit #(.AW(AW), .IR_RESET(8'hC0), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_ir      (ld_ir),
    .ld_pc      (ld_pc),
    .inc_pc     (inc_pc),
    .jmp_addr   (jmp_addr),
    .mem_rd_req (mem_rd_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ir_valid pulse must match the oldest expected IR byte.
  always @(negedge clk) begin
    if (mem_rd_req) n_req++;
    if (ir_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ir_valid: got ir_valid=1 ir=%0h expected no pulse", ir);
      end else begin
        check("ir_scoreboard", ir, exp_q.pop_front());
      end
    end
  end

  // Driver: full fetch of address a with response latency lat (>=1).
  task automatic run_fetch(input int lat, input logic [7:0] a, input bit disturb);
    int  req0;
    int  k;
    bit  seen;
    exp_q.push_back(tb_mem[a]);
    req0 = n_req;
    ld_ir = 1'b1;
    tick();
    ld_ir = 1'b0;
    check("busy_after_ld_ir", fetch_busy, 1);
    check("state_req", dbg_state, REQ);
    seen = 1'b0;
    for (k = 0; k < 8 && !seen; k++) begin
      tick();
      seen = mem_rd_req;
    end
    check("req_seen", seen, 1);
    if (!seen) begin
      exp_q.delete();
      return;
    end
    check("req_latency", k, 1);
    check("req_addr", mem_addr, a);
    if (disturb) begin
      ld_ir  = 1'b1;
      inc_pc = 1'b1;
    end
    tick();
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    check("req_one_cycle", mem_rd_req, 0);
    if (disturb) begin
      check("wait_pc_inc", pc, 32'(8'(a + 8'd1)));
      check("wait_addr_hold", mem_addr, a);
    end
    repeat (lat - 1) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = tb_mem[a];
    tick();
    mem_rvalid = 1'b0;
    check("ir_valid_pulse", ir_valid, 1);
    check("ir_value", ir, tb_mem[a]);
    check("sb_drained", exp_q.size(), 0);
    tick();
    check("ir_valid_clear", ir_valid, 0);
    check("busy_clear", fetch_busy, 0);
    check("single_req", n_req - req0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int req0;
    int k;
    reset = 1'b1; ld_ir = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0; jmp_addr = '0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'($urandom_range(0, 255));
    tb_mem[0] = 8'h41;

    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'hFE, 1'b0, 0, 8'hFE};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 0, 8'hFF};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 0, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 8'h20, 1'b0, 0, 8'h20};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 0, 8'h21};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 8'h21};
    vecs[7] = '{1'b1, 1'b0, 8'h05, 1'b1, 2, 8'h05};
    vecs[8] = '{1'b0, 1'b1, 8'h99, 1'b1, 5, 8'h06};
    vecs[9] = '{1'b1, 1'b0, 8'h80, 1'b1, 4, 8'h80};

    // Reset held two cycles
    tick();
    tick();
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 8'hC0);
    check("rst_req", mem_rd_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_err", fetch_err, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    // Vector table: PC op, then optional fetch at the resulting PC
    for (int i = 0; i < 10; i++) begin
      ld_pc    = vecs[i].ld_pc;
      inc_pc   = vecs[i].inc;
      jmp_addr = vecs[i].jmp;
      tick();
      ld_pc  = 1'b0;
      inc_pc = 1'b0;
      check($sformatf("pc_row%0d", i), pc, vecs[i].exp_pc);
      if (vecs[i].fetch) run_fetch(vecs[i].lat, vecs[i].exp_pc, 1'b0);
    end

    // ld_ir and inc_pc during WAIT
    ld_pc = 1'b1; jmp_addr = 8'h05;
    tick();
    ld_pc = 1'b0;
    run_fetch(3, 8'h05, 1'b1);
    check("pc_after_wait_inc", pc, 8'h06);

    // Stray rvalid in IDLE
    mem_rvalid = 1'b1;
    mem_rdata  = ~tb_mem[5];
    tick();
    mem_rvalid = 1'b0;
    tick();
    check("stray_rvalid_ir", ir, tb_mem[5]);
    check("stray_rvalid_state", dbg_state, IDLE);

    // Reset in the middle of WAIT
    ld_pc = 1'b1; jmp_addr = 8'h33;
    tick();
    ld_pc = 1'b0;
    ld_ir = 1'b1;
    tick();
    ld_ir = 1'b0;
    tick();
    tick();
    check("midwait_state", dbg_state, WAIT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_state", dbg_state, IDLE);
    check("abort_busy", fetch_busy, 0);
    check("abort_pc", pc, 0);
    check("abort_ir", ir, 8'hC0);
    check("abort_ir_valid", ir_valid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = tb_mem[8'h33];
    tick();
    mem_rvalid = 1'b0;
    tick();
    check("abort_late_rvalid_ir", ir, 8'hC0);

    // No response: timeout (if enabled) or indefinite WAIT
    ld_ir = 1'b1;
    tick();
    ld_ir = 1'b0;
    tick();
`ifdef FETCH_TIMEOUT_EN
    k = 0;
    while (!fetch_err && k < 40) begin
      tick();
      k++;
    end
    check("timeout_cycles", k, 16);
    check("timeout_err", fetch_err, 1);
    check("timeout_state", dbg_state, ERR);
    check("timeout_busy", fetch_busy, 0);
    check("timeout_ir", ir, 8'hC0);
    req0 = n_req;
    ld_ir = 1'b1;
    tick();
    ld_ir = 1'b0;
    repeat (4) tick();
    check("err_ignores_ld_ir", n_req - req0, 0);
    check("err_sticky", fetch_err, 1);
`else
    k = 0;
    req0 = n_req;
    repeat (30) tick();
    check("wait_forever_busy", fetch_busy, 1);
    check("wait_forever_state", dbg_state, WAIT);
    check("wait_forever_err", fetch_err, 0);
    check("wait_forever_no_req", n_req - req0, k);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_clears_err", fetch_err, 0);
    check("reset_recover_state", dbg_state, IDLE);

    // Recovery fetch after reset
    run_fetch(2, 8'h00, 1'b0);

    repeat (3) tick();
    check("sb_final_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
